// File: rtl/pipe_ctrl_pkg.sv
// Shared types and the per-stage tile-mode table for the stage-2 fp16 pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int NUM_STAGES = 7;

    // Bit s gives the reconfig tile mode while stage s is being issued.
    localparam logic [NUM_STAGES-1:0] STAGE_MODE = 7'b1111101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_e;

    typedef logic [2:0] stage_t;

endpackage

// File: rtl/next_stage_find.sv
// Priority search for the lowest stage with a nonzero length, at or above (include_current)
// or strictly above the current stage.
module next_stage_find
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic [NUM_STAGES*CNT_W-1:0] lens_i,
    input  logic [2:0]                  cur_i,
    input  logic                        incl_i,
    output logic [2:0]                  next_o,
    output logic                        found_o
);

    // Walking downward lets the lowest qualifying stage overwrite any higher one.
    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            if ((lens_i[s*CNT_W +: CNT_W] != '0) &&
                ((32'(s) > 32'(cur_i)) || (incl_i && (stage_t'(s) == cur_i)))) begin
                next_o  = stage_t'(s);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_sequencer.sv
// Start/done controlled sequencer walking the fp16 pipeline through its compute stages,
// issuing one operand slot per non-stalled cycle and draining the datapath before done.
module pipe_stage_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 4
) (
    input  logic                        CLK_i,
    input  logic                        RST_i,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic [NUM_STAGES*CNT_W-1:0] cfg_len_i,
    input  logic                        stall_i,
    output logic                        busy_o,
    output logic                        issue_o,
    output logic [2:0]                  stage_o,
    output logic [CNT_W-1:0]            step_o,
    output logic                        first_o,
    output logic                        last_o,
    output logic                        mode_o,
    output logic                        done_o
);

    localparam int DW = $clog2(DRAIN_CYC + 1);

    seq_state_e                  state_q, state_d;
    stage_t                      stage_q, stage_d;
    logic [CNT_W-1:0]            step_q, step_d;
    logic [NUM_STAGES*CNT_W-1:0] len_q, len_d;
    logic [DW-1:0]               drain_q, drain_d;

    logic [NUM_STAGES*CNT_W-1:0] find_lens;
    stage_t                      find_cur, find_next;
    logic                        find_incl, find_found;
    logic [CNT_W-1:0]            cur_len;
    logic                        step_end;

    // At start the lengths are not latched yet, so the search looks at the config port directly.
    next_stage_find #(.CNT_W(CNT_W)) u_find (
        .lens_i  (find_lens),
        .cur_i   (find_cur),
        .incl_i  (find_incl),
        .next_o  (find_next),
        .found_o (find_found)
    );

    assign cur_len  = len_q[32'(stage_q)*CNT_W +: CNT_W];
    assign step_end = (step_q == (cur_len - CNT_W'(1)));

    assign busy_o  = (state_q == RUN) || (state_q == DRAIN);
    assign issue_o = (state_q == RUN) && !stall_i && !abort_i;
    assign stage_o = stage_q;
    assign step_o  = step_q;
    assign first_o = issue_o && (step_q == '0);
    assign last_o  = issue_o && step_end;
    assign mode_o  = (state_q == RUN) ? STAGE_MODE[stage_q] : 1'b1;
    assign done_o  = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        step_d    = step_q;
        len_d     = len_q;
        drain_d   = drain_q;
        find_lens = len_q;
        find_cur  = stage_q;
        find_incl = 1'b0;

        unique case (state_q)
            IDLE: begin
                find_lens = cfg_len_i;
                find_cur  = '0;
                find_incl = 1'b1;
                if (start_i) begin
                    len_d   = cfg_len_i;
                    step_d  = '0;
                    drain_d = '0;
                    if (find_found) begin
                        stage_d = find_next;
                        state_d = RUN;
                    end else begin
                        stage_d = '0;
                        state_d = DRAIN;
                    end
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (!stall_i) begin
                    if (!step_end) begin
                        step_d = step_q + CNT_W'(1);
                    end else begin
                        step_d = '0;
                        if (find_found) begin
                            stage_d = find_next;
                        end else begin
                            drain_d = '0;
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (!stall_i) begin
                    if (drain_q == DW'(DRAIN_CYC - 1)) begin
                        state_d = DONE;
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q <= IDLE;
            stage_q <= '0;
            step_q  <= '0;
            len_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            step_q  <= step_d;
            len_q   <= len_d;
            drain_q <= drain_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_sequencer.sv
// Directed bench for pipe_stage_sequencer with a per-cycle reference model of the run plan.
module tb_pipe_stage_sequencer;

    localparam int NS    = 7;
    localparam int CW    = 16;
    localparam int DRAIN = 4;

    logic              CLK_i;
    logic              RST_i;
    logic              start_i;
    logic              abort_i;
    logic [NS*CW-1:0]  cfg_len_i;
    logic              stall_i;
    logic              busy_o;
    logic              issue_o;
    logic [2:0]        stage_o;
    logic [CW-1:0]     step_o;
    logic              first_o;
    logic              last_o;
    logic              mode_o;
    logic              done_o;

    pipe_stage_sequencer #(.CNT_W(CW), .DRAIN_CYC(DRAIN)) dut (
        .CLK_i     (CLK_i),
        .RST_i     (RST_i),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .cfg_len_i (cfg_len_i),
        .stall_i   (stall_i),
        .busy_o    (busy_o),
        .issue_o   (issue_o),
        .stage_o   (stage_o),
        .step_o    (step_o),
        .first_o   (first_o),
        .last_o    (last_o),
        .mode_o    (mode_o),
        .done_o    (done_o)
    );

    initial CLK_i = 1'b0;
    always #5 CLK_i = ~CLK_i;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int issue_cnt = 0;
    int mode0_cnt = 0;
    int done_cnt  = 0;
    bit mon_en = 1'b0;

    // Reference model: ordered list of nonzero stages plus a cursor, then a drain countdown.
    bit m_active = 1'b0;
    int mq[$];
    int m_len[NS];
    int m_step  = 0;
    int m_drain = 0;

    always @(posedge CLK_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [NS*CW-1:0] mk(input int l0, input int l1, input int l2, input int l3,
                                            input int l4, input int l5, input int l6);
        return {16'(l6), 16'(l5), 16'(l4), 16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    task automatic monitor_step();
        int e_busy, e_issue, e_done, e_mode, e_first, e_last, e_stage, e_step;
        e_busy = 0; e_issue = 0; e_done = 0; e_mode = 1;
        e_first = 0; e_last = 0; e_stage = 0; e_step = 0;
        if (m_active) begin
            if (mq.size() > 0) begin
                e_busy  = 1;
                e_stage = mq[0];
                e_step  = m_step;
                e_issue = (!stall_i && !abort_i) ? 1 : 0;
                e_first = (e_issue == 1 && m_step == 0) ? 1 : 0;
                e_last  = (e_issue == 1 && m_step == m_len[mq[0]] - 1) ? 1 : 0;
                e_mode  = (mq[0] != 1) ? 1 : 0;
            end else if (m_drain > 0) begin
                e_busy = 1;
            end else begin
                e_done = 1;
            end
        end
        chk("busy_o",  busy_o,  e_busy);
        chk("issue_o", issue_o, e_issue);
        chk("done_o",  done_o,  e_done);
        chk("mode_o",  mode_o,  e_mode);
        chk("first_o", first_o, e_first);
        chk("last_o",  last_o,  e_last);
        if (e_issue == 1) begin
            chk("stage_o", stage_o, e_stage);
            chk("step_o",  step_o,  e_step);
        end
        if (issue_o) issue_cnt++;
        if (issue_o && !mode_o) mode0_cnt++;
        if (done_o) done_cnt++;

        // Advance the model to what the coming edge must produce.
        if (RST_i) begin
            m_active = 1'b0;
            mq.delete();
        end else if (!m_active) begin
            if (start_i) begin
                mq.delete();
                for (int s = 0; s < NS; s++) begin
                    m_len[s] = int'(cfg_len_i[s*CW +: CW]);
                    if (m_len[s] != 0) mq.push_back(s);
                end
                m_step   = 0;
                m_drain  = DRAIN;
                m_active = 1'b1;
            end
        end else if (mq.size() > 0) begin
            if (abort_i) begin
                m_active = 1'b0;
                mq.delete();
            end else if (!stall_i) begin
                if (m_step == m_len[mq[0]] - 1) begin
                    void'(mq.pop_front());
                    m_step = 0;
                end else begin
                    m_step++;
                end
            end
        end else if (m_drain > 0) begin
            if (abort_i) m_active = 1'b0;
            else if (!stall_i) m_drain--;
        end else begin
            m_active = 1'b0;
        end
    endtask

    always @(negedge CLK_i) if (mon_en) monitor_step();

    task automatic tick();
        @(posedge CLK_i);
        #1;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done_o && n < bound) begin
            tick();
            n++;
        end
        chk("done_seen", done_o, 1);
    endtask

    task automatic run_and_wait(input logic [NS*CW-1:0] lens, input int bound, output int lat);
        int s;
        cfg_len_i = lens;
        start_i   = 1'b1;
        s = cyc;
        tick();
        start_i = 1'b0;
        wait_done(bound);
        lat = cyc - s;
        tick();
    endtask

    initial begin
        int lat, s, i0, m0, d0;
        RST_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; stall_i = 1'b0; cfg_len_i = '0;
        tick();
        mon_en = 1'b1;
        tick();
        RST_i = 1'b0;
        chk("rst_busy",  busy_o,  0);
        chk("rst_issue", issue_o, 0);
        chk("rst_stage", stage_o, 0);
        chk("rst_step",  step_o,  0);
        chk("rst_mode",  mode_o,  1);
        chk("rst_done",  done_o,  0);
        tick();

        // Mixed lengths with skipped stages.
        i0 = issue_cnt; m0 = mode0_cnt;
        run_and_wait(mk(3, 2, 0, 1, 0, 0, 2), 100, lat);
        chk("mix_latency", lat, 13);
        chk("mix_issues", issue_cnt - i0, 8);
        chk("mix_mode0_issues", mode0_cnt - m0, 2);

        // All lengths zero.
        i0 = issue_cnt;
        run_and_wait(mk(0, 0, 0, 0, 0, 0, 0), 100, lat);
        chk("zero_latency", lat, DRAIN + 1);
        chk("zero_issues", issue_cnt - i0, 0);

        // Three-cycle stall at step 2.
        cfg_len_i = mk(4, 0, 0, 0, 0, 0, 0);
        start_i = 1'b1;
        s = cyc;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_step", step_o, 2);
            chk("stall_issue", issue_o, 0);
            tick();
        end
        stall_i = 1'b0;
        wait_done(100);
        chk("stall_latency", cyc - s, 12);
        tick();

        // Abort at stage 1 step 1, then a clean rerun.
        cfg_len_i = mk(1, 2, 0, 0, 0, 0, 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        chk("abort_stage", stage_o, 1);
        chk("abort_step", step_o, 1);
        abort_i = 1'b1;
        #1;
        chk("abort_issue", issue_o, 0);
        tick();
        abort_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        d0 = done_cnt;
        repeat (10) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        run_and_wait(mk(3, 2, 0, 1, 0, 0, 2), 100, lat);
        chk("rerun_latency", lat, 13);

        // Reset during DRAIN with start held.
        cfg_len_i = mk(2, 0, 0, 0, 0, 0, 0);
        start_i = 1'b1;
        repeat (4) tick();
        chk("drain_busy", busy_o, 1);
        chk("drain_issue", issue_o, 0);
        RST_i = 1'b1;
        start_i = 1'b0;
        d0 = done_cnt;
        tick();
        RST_i = 1'b0;
        chk("mid_rst_busy",  busy_o,  0);
        chk("mid_rst_stage", stage_o, 0);
        chk("mid_rst_step",  step_o,  0);
        chk("mid_rst_mode",  mode_o,  1);
        chk("mid_rst_done",  done_o,  0);
        repeat (8) tick();
        chk("mid_rst_no_done", done_cnt - d0, 0);

        // Single-element stage.
        cfg_len_i = mk(1, 0, 0, 0, 0, 0, 0);
        start_i = 1'b1;
        s = cyc;
        tick();
        start_i = 1'b0;
        chk("len1_issue", issue_o, 1);
        chk("len1_first", first_o, 1);
        chk("len1_last",  last_o,  1);
        wait_done(100);
        chk("len1_latency", cyc - s, 6);
        tick();

        // Maximum length followed by a one-element stage.
        i0 = issue_cnt;
        run_and_wait(mk(65535, 1, 0, 0, 0, 0, 0), 70000, lat);
        chk("max_latency", lat, 65535 + 1 + DRAIN + 1);
        chk("max_issues", issue_cnt - i0, 65536);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
